// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and protocol constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAITIDLE
  } ps2_state_e;

  // Common keyboard command / response bytes.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // PS/2 uses odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on clock and data, a run-length
// glitch filter on the clock, and a one-cycle pulse on each filtered fall.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic kclk_i,
  input  logic kdata_i,
  output logic kclk_o,
  output logic kdata_o,
  output logic kfall_o
);

  localparam int RW = $clog2(FILTER_LEN + 1);

  logic [1:0]    kclk_sync_q;
  logic [1:0]    kdata_sync_q;
  logic          kclk_filt_q;
  logic [RW-1:0] run_q;
  logic          kfall_q;

  // Synchronise both pins; accept a clock level only after FILTER_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      kclk_sync_q  <= 2'b11;
      kdata_sync_q <= 2'b11;
      kclk_filt_q  <= 1'b1;
      run_q        <= '0;
      kfall_q      <= 1'b0;
    end else begin
      kclk_sync_q  <= {kclk_sync_q[0], kclk_i};
      kdata_sync_q <= {kdata_sync_q[0], kdata_i};
      kfall_q      <= 1'b0;
      if (kclk_sync_q[1] != kclk_filt_q) begin
        if (run_q == RW'(FILTER_LEN - 1)) begin
          kclk_filt_q <= kclk_sync_q[1];
          run_q       <= '0;
          kfall_q     <= kclk_filt_q;  // old level 1 -> new level 0
        end else begin
          run_q <= run_q + 1'b1;
        end
      end else begin
        run_q <= '0;
      end
    end
  end

  assign kclk_o  = kclk_filt_q;
  assign kdata_o = kdata_sync_q[1];
  assign kfall_o = kfall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-bit frame
// clocked by the device, ACK capture, and a per-bit timeout.
// INHIBIT_CYCLES must not exceed TIMEOUT_CYCLES (they share one counter).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tdata,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_drive_low,
  output logic       kdata_drive_low,
  output logic       busy,
  output logic       rx_block,
  output logic       done,
  output logic       ack_ok,
  output logic       err_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic kclk_f, kdata_s, kfall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk     (clk),
    .rst     (rst),
    .kclk_i  (kclk_in),
    .kdata_i (kdata_in),
    .kclk_o  (kclk_f),
    .kdata_o (kdata_s),
    .kfall_o (kfall)
  );

  ps2_state_e    state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitn_q;
  logic [9:0]    shreg_q;  // {stop, parity, D7..D0}, shifted out LSB first
  logic          kclk_low_q, kdata_low_q, busy_q, done_q, ack_ok_q, err_q;
  logic          lines_idle, tmo;

  // Saturating count so a stuck line can never wrap back to a small value.
  assign cnt_d      = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
  assign lines_idle = kclk_f & kdata_s;
  // Abort only when no progress is made on this very cycle.
  assign tmo = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !kfall &&
               ((state_q == SEND) || (state_q == ACK) ||
                (state_q == WAITIDLE && !lines_idle));

  // Transfer FSM with registered line drives and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitn_q      <= '0;
      shreg_q     <= '0;
      kclk_low_q  <= 1'b0;
      kdata_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_ok_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (tmo) begin
        kclk_low_q  <= 1'b0;
        kdata_low_q <= 1'b0;
        err_q       <= 1'b1;
        state_q     <= IDLE;
      end else begin
        if (state_q == SEND || state_q == ACK || state_q == WAITIDLE)
          cnt_q <= kfall ? '0 : cnt_d;
        case (state_q)
          IDLE: begin
            busy_q <= 1'b0;
            // busy_q is still high during the done/err cycle, so no start is taken then.
            if (start && !busy_q) begin
              busy_q     <= 1'b1;
              ack_ok_q   <= 1'b0;
              shreg_q    <= {1'b1, odd_parity(tdata), tdata};
              cnt_q      <= '0;
              kclk_low_q <= 1'b1;
              state_q    <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
              kclk_low_q  <= 1'b0;
              kdata_low_q <= 1'b1;  // start bit doubles as request-to-send
              cnt_q       <= '0;
              bitn_q      <= '0;
              state_q     <= SEND;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          SEND: begin
            if (kfall) begin
              kdata_low_q <= ~shreg_q[0];
              shreg_q     <= {1'b0, shreg_q[9:1]};
              bitn_q      <= bitn_q + 1'b1;
              if (bitn_q == 4'd9) state_q <= ACK;  // tenth fall released data (stop)
            end
          end
          ACK: begin
            if (kfall) begin
              ack_ok_q <= ~kdata_s;
              state_q  <= WAITIDLE;
            end
          end
          WAITIDLE: begin
            if (lines_idle) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign kclk_drive_low  = kclk_low_q;
  assign kdata_drive_low = kdata_low_q;
  assign busy            = busy_q;
  assign rx_block        = busy_q;
  assign done            = done_q;
  assign ack_ok          = ack_ok_q;
  assign err_timeout     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 2000;
  localparam int HALF = 4000;  // half of the 8000-unit device clock period (clk period = 10)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       kclk_drive_low, kdata_drive_low, busy, rx_block, done, ack_ok, err_timeout;
  logic       kclk_line, kdata_line;

  assign kclk_line  = ~(kclk_drive_low | dev_clk_low);
  assign kdata_line = ~(kdata_drive_low | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .tdata           (tdata),
    .kclk_in         (kclk_line),
    .kdata_in        (kdata_line),
    .kclk_drive_low  (kclk_drive_low),
    .kdata_drive_low (kdata_drive_low),
    .busy            (busy),
    .rx_block        (rx_block),
    .done            (done),
    .ack_ok          (ack_ok),
    .err_timeout     (err_timeout)
  );

  int   n_chk = 0, n_pass = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, rxb_mis = 0;
  logic ack_at_done = 1'b0;

  // Pulse monitor
  always @(negedge clk) begin
    if (done) begin done_cnt++; ack_at_done = ack_ok; end
    if (err_timeout) err_cnt++;
    if (done && err_timeout) both_cnt++;
    if (rx_block !== busy) rxb_mis++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk); start = 1'b1; tdata = b;
    @(negedge clk); start = 1'b0;
  endtask

  // Keyboard model. falls<0: never clock; falls>0: stop after that many falls; 0: full frame.
  task automatic dev_frame(input logic ack, input int falls, output int inh, output logic rts,
                           output logic sb, output logic [9:0] fr);
    inh = 0; rts = 1'b0; sb = 1'b1; fr = '0;
    while (kclk_drive_low && inh < 1000) begin @(negedge clk); inh++; end
    rts = kdata_drive_low;
    if (falls < 0) return;
    #HALF;
    sb = kdata_line;
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1; #HALF;
      dev_clk_low = 1'b0; fr[i] = kdata_line; #HALF;
      if (i + 1 == falls) return;
    end
    dev_data_low = ack; #(HALF/2);
    dev_clk_low  = 1'b1; #HALF;
    dev_clk_low  = 1'b0; #(HALF/2);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  typedef struct { logic [7:0] d; logic ack; logic par; } vec_t;
  vec_t vecs[3] = '{'{8'hED, 1'b1, 1'b1}, '{8'h01, 1'b1, 1'b0}, '{8'hFF, 1'b1, 1'b1}};

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int inh, k, d0, e0;
    logic rts, sb;
    logic [9:0] fr;

    repeat (4) @(negedge clk);
    chk("reset_outs", {26'd0, kclk_drive_low, kdata_drive_low, busy, done, ack_ok, err_timeout}, 32'd0);
    rst = 1'b0;

    // Normal frames with ACK
    foreach (vecs[v]) begin
      d0 = done_cnt; e0 = err_cnt;
      pulse_start(vecs[v].d);
      dev_frame(vecs[v].ack, 0, inh, rts, sb, fr);
      wait_done(d0);
      chk("inhibit_len", inh, INH);
      chk("rts", rts, 1);
      chk("start_bit", sb, 0);
      chk("data", fr[7:0], vecs[v].d);
      chk("parity", fr[8], vecs[v].par);
      chk("stop", fr[9], 1);
      chk("done_cnt", done_cnt - d0, 1);
      chk("ack_at_done", ack_at_done, vecs[v].ack);
      chk("ack_hold", ack_ok, vecs[v].ack);
      chk("no_err", err_cnt - e0, 0);
      chk("idle_out", {busy, kclk_drive_low, kdata_drive_low}, 3'b000);
    end

    // Timeout: device never clocks after RTS
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'hED);
    dev_frame(1'b1, -1, inh, rts, sb, fr);
    k = 0;
    while (!err_timeout && k < 3000) begin @(negedge clk); k++; end
    chk("tmo_cycles", k, TMO);
    chk("tmo_lines", {kclk_drive_low, kdata_drive_low}, 2'b00);
    @(negedge clk);
    chk("tmo_busy", busy, 0);
    chk("tmo_err_cnt", err_cnt - e0, 1);
    chk("tmo_no_done", done_cnt - d0, 0);

    // Second start while busy is ignored; device NACKs
    d0 = done_cnt;
    pulse_start(8'h12);
    @(negedge clk); start = 1'b1; tdata = 8'h55;
    @(negedge clk); start = 1'b0;
    dev_frame(1'b0, 0, inh, rts, sb, fr);
    wait_done(d0);
    repeat (200) @(negedge clk);
    chk("busy_data", fr[7:0], 8'h12);
    chk("busy_parity", fr[8], 1);
    chk("busy_one_done", done_cnt - d0, 1);
    chk("nack_at_done", ack_at_done, 0);
    chk("nack_hold", ack_ok, 0);
    chk("nack_lines", {busy, kclk_drive_low, kdata_drive_low}, 3'b000);

    // Reset in mid-frame, then a normal frame
    d0 = done_cnt; e0 = err_cnt;
    pulse_start(8'hA5);
    dev_frame(1'b1, 5, inh, rts, sb, fr);
    chk("pre_rst_state", {busy, kdata_drive_low}, 2'b11);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {kclk_drive_low, kdata_drive_low, busy, done, err_timeout}, 5'd0);
    rst = 1'b0;
    chk("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    pulse_start(8'hF4);
    dev_frame(1'b1, 0, inh, rts, sb, fr);
    wait_done(d0);
    chk("f4_data", fr[7:0], 8'hF4);
    chk("f4_parity", fr[8], 0);
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_ack", ack_ok, 1);

    chk("no_overlap", both_cnt, 0);
    chk("rx_block_eq_busy", rxb_mis, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
